fifo_param: RTL and testbench
=============================

Name: fifo_param

Overview:
- Parametrised synchronous FIFO; next generation of the 6-bit, 4-deep channel FIFO.
- Generalised data width and depth, with run-time programmable almost-empty/almost-full thresholds and a registered read port with valid strobe.
- Sticky, separately reported overflow/underflow errors and an exported fill level.
- Sits between the channel router and the downstream consumer; pausa drives upstream flow control.

Parameters:
DATA_WIDTH, 6, word width in bits
ADDR_WIDTH, 2, pointer width; DEPTH = 2**ADDR_WIDTH entries (min ADDR_WIDTH=1)

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  asynchronous, active-high reset
push  input  1  write request
pop  input  1  read request
data_in  input  DATA_WIDTH  write data
umbral_bajo  input  ADDR_WIDTH+1  almost-empty threshold
umbral_alto  input  ADDR_WIDTH+1  almost-full threshold
err_clr  input  1  clears sticky error flags
data_out  output  DATA_WIDTH  read data, registered
valid_out  output  1  one-cycle pulse: data_out updated by accepted pop
fill_level  output  ADDR_WIDTH+1  current occupancy 0..DEPTH
fifo_empty  output  1  fill_level==0
fifo_full  output  1  fill_level==DEPTH
almost_empty  output  1  0 < fill_level <= umbral_bajo
almost_full  output  1  umbral_alto <= fill_level < DEPTH
pausa  output  1  fill_level >= umbral_alto (includes full)
error_overflow  output  1  sticky: push rejected while full
error_underflow  output  1  sticky: pop rejected while empty

Behaviour:
- Reset (async, while reset=1): ptrs=0, fill_level=0, data_out=0, valid_out=0, fifo_empty=1, all other flags/errors 0. Memory contents not reset. Reset mid-operation discards all stored data.
- Storage: internal DEPTH x DATA_WIDTH register array. wr_ptr/rd_ptr are ADDR_WIDTH bits and wrap naturally modulo DEPTH. Count is a separate ADDR_WIDTH+1 counter.
- Accept rules, evaluated on pre-edge state:
  - push_ok = push & (!full | pop_ok)
  - pop_ok = pop & !empty
- Write: push_ok -> mem[wr_ptr]<=data_in, wr_ptr+1.
- Read: pop_ok -> data_out<=mem[rd_ptr], rd_ptr+1, valid_out=1 next cycle. Latency is one clock from pop edge to data_out/valid_out. data_out holds its last value otherwise.
- Count: +1 if push_ok only; -1 if pop_ok only; unchanged if both or neither.
- Simultaneous push+pop:
  - Full: both accepted, level stays DEPTH, no overflow.
  - Empty: push accepted, pop rejected, underflow set, level becomes 1. No bypass: a written word is never readable in the same cycle.
- Errors: error_overflow set when push & full & !pop_ok. error_underflow set when pop & empty. Both hold until err_clr. If err_clr and a new error occur in the same cycle, set wins.
- Flags: registered, computed from next-state count and current thresholds, so they change on the same edge as fill_level. Threshold changes take effect on the next edge.
- Degenerate thresholds: umbral_bajo=0 -> almost_empty never asserts. umbral_alto > DEPTH -> almost_full/pausa never assert. umbral_alto=0 -> pausa always 1, almost_full = (level<DEPTH).
- Width rule: all comparisons unsigned, ADDR_WIDTH+1 bits. No truncation of count at DEPTH.

Optional Feature:
- FIFO_PEAK_EN defined: adds output peak_level [ADDR_WIDTH:0], reset 0. Registers max(peak_level, next fill_level) each edge; err_clr reloads it with the next fill_level.
- Not defined: port and logic absent; interface otherwise identical.

Test Plan (DATA_WIDTH=6, ADDR_WIDTH=2, umbral_bajo=1, umbral_alto=3):
- Fill: after reset, push 0x11,0x22,0x33,0x04 on 4 consecutive cycles. Required:
  - fill_level 1,2,3,4
  - almost_empty=1 only at level 1
  - almost_full and pausa=1 at level 3
  - fifo_full=1 and almost_full=0 at level 4; pausa stays 1
- Overflow: at full, push 0x3F alone -> fill_level stays 4, error_overflow=1 and stays 1 until err_clr pulse, contents unchanged.
- Drain/latency: pop 4 cycles from full -> valid_out pulses each following cycle with data_out 0x11,0x22,0x33,0x04. fifo_empty=1 after the 4th; a 5th pop -> error_underflow=1, valid_out=0, data_out holds 0x04.
- Simultaneous at full and empty:
  - Full + push 0x2A & pop together: level stays 4, data_out = oldest word, no error.
  - Empty + push & pop together: level becomes 1, error_underflow=1.
- Wrap and async reset: 10 push/pop pairs crossing pointer wrap keep data in order. Assert reset mid-stream at level 2 -> immediately level 0, fifo_empty=1, errors 0, data_out=0.
- FIFO_PEAK_EN: fill to 3, drain to 0 -> peak_level=3. err_clr at level 0 -> peak_level=0.

Source files
------------

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with programmable almost-empty/almost-full thresholds,
// registered read port, sticky errors and fill level. Define FIFO_PEAK_EN to add peak_level.
module fifo_param #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ADDR_WIDTH:0]   umbral_bajo,
    input  logic [ADDR_WIDTH:0]   umbral_alto,
    input  logic                  err_clr,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic [ADDR_WIDTH:0]   fill_level,
    output logic                  fifo_empty,
    output logic                  fifo_full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic                  pausa,
    output logic                  error_overflow,
`ifdef FIFO_PEAK_EN
    output logic                  error_underflow,
    output logic [ADDR_WIDTH:0]   peak_level
`else
    output logic                  error_underflow
`endif
);

    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [DATA_WIDTH-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];
    logic [ADDR_WIDTH-1:0] r_wrPtr;
    logic [ADDR_WIDTH-1:0] r_rdPtr;
    logic [ADDR_WIDTH:0]   r_count;
    logic [DATA_WIDTH-1:0] r_dataOut;
    logic                  r_valid;
    logic                  r_empty;
    logic                  r_full;
    logic                  r_almostEmpty;
    logic                  r_almostFull;
    logic                  r_pausa;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_isFull;
    logic                  w_isEmpty;
    logic                  w_popOk;
    logic                  w_pushOk;
    logic [ADDR_WIDTH:0]   w_countNext;

    // Accept decisions use pre-edge occupancy; a pop frees a slot for a push at full,
    // but a push never feeds a pop at empty (no bypass path).
    always_comb begin
        w_isFull    = (r_count == DEPTH);
        w_isEmpty   = (r_count == '0);
        w_popOk     = pop & ~w_isEmpty;
        w_pushOk    = push & (~w_isFull | w_popOk);
        w_countNext = r_count;
        if (w_pushOk && !w_popOk) begin
            w_countNext = r_count + (ADDR_WIDTH+1)'(1);
        end else if (w_popOk && !w_pushOk) begin
            w_countNext = r_count - (ADDR_WIDTH+1)'(1);
        end
    end

    // Storage array is deliberately not reset; stale words are unreachable once pointers clear.
    always_ff @(posedge clk) begin
        if (w_pushOk) begin
            r_mem[r_wrPtr] <= data_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wrPtr   <= '0;
            r_rdPtr   <= '0;
            r_count   <= '0;
            r_dataOut <= '0;
            r_valid   <= 1'b0;
        end else begin
            r_valid <= w_popOk;
            r_count <= w_countNext;
            if (w_pushOk) begin
                r_wrPtr <= r_wrPtr + ADDR_WIDTH'(1);
            end
            if (w_popOk) begin
                r_dataOut <= r_mem[r_rdPtr];
                r_rdPtr   <= r_rdPtr + ADDR_WIDTH'(1);
            end
        end
    end

    // Flags look at the next count so they move on the same edge as fill_level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_empty       <= 1'b1;
            r_full        <= 1'b0;
            r_almostEmpty <= 1'b0;
            r_almostFull  <= 1'b0;
            r_pausa       <= 1'b0;
        end else begin
            r_empty       <= (w_countNext == '0);
            r_full        <= (w_countNext == DEPTH);
            r_almostEmpty <= (w_countNext != '0) && (w_countNext <= umbral_bajo);
            r_almostFull  <= (w_countNext >= umbral_alto) && (w_countNext < DEPTH);
            r_pausa       <= (w_countNext >= umbral_alto);
        end
    end

    // Sticky errors: a new error in the same cycle as err_clr keeps the flag set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= (push & w_isFull & ~w_popOk) | (r_overflow & ~err_clr);
            r_underflow <= (pop & w_isEmpty) | (r_underflow & ~err_clr);
        end
    end

`ifdef FIFO_PEAK_EN
    logic [ADDR_WIDTH:0] r_peak;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_peak <= '0;
        end else if (err_clr) begin
            r_peak <= w_countNext;
        end else if (w_countNext > r_peak) begin
            r_peak <= w_countNext;
        end
    end

    assign peak_level = r_peak;
`endif

    assign data_out        = r_dataOut;
    assign valid_out       = r_valid;
    assign fill_level      = r_count;
    assign fifo_empty      = r_empty;
    assign fifo_full       = r_full;
    assign almost_empty    = r_almostEmpty;
    assign almost_full     = r_almostFull;
    assign pausa           = r_pausa;
    assign error_overflow  = r_overflow;
    assign error_underflow = r_underflow;

endmodule

// File: tb/tb_fifo_param.sv
// Self-checking bench for fifo_param: a reference model with a data scoreboard queue
// predicts every output after each clock edge, including the optional peak_level.
module tb_fifo_param;

    logic       clk = 1'b0;
    logic       reset;
    logic       push;
    logic       pop;
    logic [5:0] data_in;
    logic [2:0] umbral_bajo;
    logic [2:0] umbral_alto;
    logic       err_clr;
    logic [5:0] data_out;
    logic       valid_out;
    logic [2:0] fill_level;
    logic       fifo_empty;
    logic       fifo_full;
    logic       almost_empty;
    logic       almost_full;
    logic       pausa;
    logic       error_overflow;
    logic       error_underflow;
`ifdef FIFO_PEAK_EN
    logic [2:0] peak_level;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [5:0] sb[$];
    int         mCount;
    logic [5:0] mDataOut;
    logic       mValid;
    logic       mEmpty, mFull, mAe, mAf, mPausa, mOvf, mUnf;
    int         mPeak;

    fifo_param #(.DATA_WIDTH(6), .ADDR_WIDTH(2)) dut (
        .clk(clk),
        .reset(reset),
        .push(push),
        .pop(pop),
        .data_in(data_in),
        .umbral_bajo(umbral_bajo),
        .umbral_alto(umbral_alto),
        .err_clr(err_clr),
        .data_out(data_out),
        .valid_out(valid_out),
        .fill_level(fill_level),
        .fifo_empty(fifo_empty),
        .fifo_full(fifo_full),
        .almost_empty(almost_empty),
        .almost_full(almost_full),
        .pausa(pausa),
        .error_overflow(error_overflow),
`ifdef FIFO_PEAK_EN
        .error_underflow(error_underflow),
        .peak_level(peak_level)
`else
        .error_underflow(error_underflow)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".fill"}, 32'(fill_level), 32'(mCount));
        checkOutput({tag, ".empty"}, 32'(fifo_empty), 32'(mEmpty));
        checkOutput({tag, ".full"}, 32'(fifo_full), 32'(mFull));
        checkOutput({tag, ".aempty"}, 32'(almost_empty), 32'(mAe));
        checkOutput({tag, ".afull"}, 32'(almost_full), 32'(mAf));
        checkOutput({tag, ".pausa"}, 32'(pausa), 32'(mPausa));
        checkOutput({tag, ".ovf"}, 32'(error_overflow), 32'(mOvf));
        checkOutput({tag, ".unf"}, 32'(error_underflow), 32'(mUnf));
        checkOutput({tag, ".valid"}, 32'(valid_out), 32'(mValid));
        checkOutput({tag, ".dout"}, 32'(data_out), 32'(mDataOut));
`ifdef FIFO_PEAK_EN
        checkOutput({tag, ".peak"}, 32'(peak_level), 32'(mPeak));
`endif
    endtask

    task automatic modelReset();
        sb.delete();
        mCount = 0; mDataOut = '0; mValid = 1'b0;
        mEmpty = 1'b1; mFull = 1'b0; mAe = 1'b0; mAf = 1'b0; mPausa = 1'b0;
        mOvf = 1'b0; mUnf = 1'b0; mPeak = 0;
    endtask

    // One clock of stimulus; the model predicts from pre-edge state, then outputs are compared.
    task automatic applyStimulus(input string tag, input logic p, input logic q,
                                 input logic [5:0] d, input logic clr);
        logic popOk, pushOk, ovfSet, unfSet;
        int lo, hi;
        push = p; pop = q; data_in = d; err_clr = clr;
        lo = int'(umbral_bajo); hi = int'(umbral_alto);
        popOk  = q && (mCount != 0);
        pushOk = p && ((mCount != 4) || popOk);
        ovfSet = p && (mCount == 4) && !popOk;
        unfSet = q && (mCount == 0);
        @(posedge clk);
        if (pushOk) sb.push_back(d);
        mValid = popOk;
        if (popOk) mDataOut = sb.pop_front();
        mCount = mCount + int'(pushOk) - int'(popOk);
        mOvf   = ovfSet | (mOvf & ~clr);
        mUnf   = unfSet | (mUnf & ~clr);
        mEmpty = (mCount == 0);
        mFull  = (mCount == 4);
        mAe    = (mCount != 0) && (mCount <= lo);
        mAf    = (mCount >= hi) && (mCount < 4);
        mPausa = (mCount >= hi);
        mPeak  = clr ? mCount : ((mCount > mPeak) ? mCount : mPeak);
        #1;
        checkAll(tag);
        push = 1'b0; pop = 1'b0; err_clr = 1'b0;
    endtask

    initial begin
        reset = 1'b1; push = 1'b0; pop = 1'b0; data_in = '0; err_clr = 1'b0;
        umbral_bajo = 3'd1; umbral_alto = 3'd3;
        modelReset();
        #12;
        checkAll("reset");
        @(posedge clk); #1;
        reset = 1'b0;

        // Fill to full, then overflow attempts
        applyStimulus("fill1", 1, 0, 6'h11, 0);
        applyStimulus("fill2", 1, 0, 6'h22, 0);
        applyStimulus("fill3", 1, 0, 6'h33, 0);
        applyStimulus("fill4", 1, 0, 6'h04, 0);
        applyStimulus("ovf", 1, 0, 6'h3F, 0);
        applyStimulus("ovfHold", 0, 0, 6'h00, 0);
        applyStimulus("ovfClr", 0, 0, 6'h00, 1);

        // Drain with one-cycle latency, then underflow
        for (int i = 0; i < 4; i++) applyStimulus("drain", 0, 1, 6'h00, 0);
        applyStimulus("unf", 0, 1, 6'h00, 0);
        applyStimulus("unfClr", 0, 0, 6'h00, 1);

        // Simultaneous push/pop at full and at empty
        for (int i = 0; i < 4; i++) applyStimulus("refill", 1, 0, 6'(8 + i), 0);
        applyStimulus("bothFull", 1, 1, 6'h2A, 0);
        for (int i = 0; i < 4; i++) applyStimulus("drain2", 0, 1, 6'h00, 0);
        applyStimulus("bothEmpty", 1, 1, 6'h15, 0);
        applyStimulus("errClrSet", 0, 1, 6'h00, 1);
        applyStimulus("errClr", 0, 0, 6'h00, 1);

        // Pointer wrap with paired push/pop, then async reset at level 2
        applyStimulus("prime", 1, 0, 6'h07, 0);
        for (int i = 0; i < 10; i++) applyStimulus("wrap", 1, 1, 6'($urandom_range(0, 63)), 0);
        applyStimulus("lvl2", 1, 0, 6'h19, 0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        modelReset();
        checkAll("asyncRst");
        @(posedge clk); #1;
        reset = 1'b0;

        // Peak tracking: fill to 3, drain, then clear at level 0
        for (int i = 0; i < 3; i++) applyStimulus("peakFill", 1, 0, 6'(i + 1), 0);
        for (int i = 0; i < 3; i++) applyStimulus("peakDrain", 0, 1, 6'h00, 0);
        applyStimulus("peakClr", 0, 0, 6'h00, 1);

        // Degenerate thresholds and random traffic
        umbral_bajo = 3'd0; umbral_alto = 3'd5;
        for (int i = 0; i < 6; i++) applyStimulus("degHi", 1, 0, 6'(i), 0);
        umbral_alto = 3'd0;
        for (int i = 0; i < 6; i++) applyStimulus("degZero", 0, 1, 6'h00, 0);
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                umbral_bajo = 3'($urandom_range(0, 7));
                umbral_alto = 3'($urandom_range(0, 7));
            end
            applyStimulus("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          6'($urandom_range(0, 63)), ($urandom_range(0, 9) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
